parking_alloc: RTL and testbench
================================

Name: parking_alloc

Overview:
- Allocation side of the parking occupancy interface. It grants a free slot to an arriving car, drives the entry gate, and frees slots when cars leave.
- It owns the registered occupancy vector, one bit per slot, which downstream counting logic consumes.
- It reports the occupied count, the available count and the full status, all derived from that vector.

Parameters:
- NUM_SLOTS, 8, number of parking slots (2..15, so that counts fit in 4 bits).
- GATE_CYCLES, 4, number of clock cycles gate_open stays high per granted entry (>=1).
- IDW, $clog2(NUM_SLOTS), width of the slot index (derived, not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- entry_req  input  1  car waiting at entry; level, held until entry_grant.
- exit_valid  input  1  one-cycle pulse: the car in exit_slot has left.
- exit_slot  input  IDW  slot being vacated; qualified by exit_valid.
- entry_grant  output  1  one-cycle pulse: a slot is allocated.
- grant_slot  output  IDW  allocated slot index; valid while entry_grant is high, otherwise holds its last value.
- gate_open  output  1  entry barrier open.
- exit_err  output  1  one-cycle pulse: exit for an already free or out-of-range slot.
- occ  output  NUM_SLOTS  occupancy vector, bit i = slot i occupied.
- num  output  4  occupied count.
- avail  output  4  NUM_SLOTS - num.
- full  output  1  all slots occupied.

Behaviour:
- Reset: clk is the single clock; rst is asynchronous and active-high. While rst is high: occ=0, entry_grant=0, grant_slot=0, gate_open=0, exit_err=0, FSM=IDLE. Derived outputs then read num=0, avail=NUM_SLOTS, full=0.
- Reset mid-operation aborts any grant or gate cycle immediately and frees all slots.
- FSM states:
  - IDLE: gate closed. If entry_req=1 and full=0 at a clock edge, go to GRANT. If full=1, stay in IDLE; the request stays pending with no grant.
  - GRANT: lasts exactly one cycle. entry_grant=1 and grant_slot = the lowest-index free slot, computed from occ at the IDLE->GRANT edge. occ[grant_slot] is set at the GRANT exit edge. Next state is OPEN.
  - OPEN: gate_open=1 for exactly GATE_CYCLES cycles, counted by an internal down-counter. Then return to IDLE.
  - entry_req is ignored outside IDLE. A car still requesting in IDLE is served again, so the requester must drop entry_req after seeing entry_grant.
- Latency: entry_req sampled high in IDLE at edge N gives entry_grant high in cycle N+1, then gate_open high in cycles N+2 .. N+1+GATE_CYCLES.
- Exit handling is independent of FSM state, and is registered:
  - If exit_valid=1, exit_slot<NUM_SLOTS and occ[exit_slot]=1, clear the bit at the next edge.
  - Otherwise no change to occ, and exit_err pulses high in the next cycle.
- Simultaneous events:
  - Exit and grant-set in the same edge are both applied.
  - The chosen slot is free before the exit, so the exit and the set can never target the same bit.
  - A full lot with a pending entry_req: an exit frees a slot at edge N. full drops, so the grant is issued at edge N+1, in cycle N+2.
  - Free-slot selection uses occ only. A slot freed in the same edge is not eligible until the following cycle.
- Arithmetic and width:
  - num is a combinational popcount of occ, zero-extended to 4 bits.
  - avail = NUM_SLOTS - num in 4 bits; it never underflows because num <= NUM_SLOTS.
  - full = &occ.
- Invariant: num never exceeds NUM_SLOTS, and there is no allocation while full.

Decomposition:
- Shared package parking_pkg holds:
  - the state enum {IDLE, GRANT, OPEN};
  - default constants NUM_SLOTS=8 and GATE_CYCLES=4;
  - the count width CNT_W=4.
- One natural sub-module, parking_free_find: a combinational lowest-free-slot priority encoder. Input occ; outputs idx[IDW] and any_free.
- Popcount for num/avail lives in this block; it is the same function the occupancy counter performs.

Test Plan:
- Reset check: assert rst mid-OPEN with occ=8'hFF -> occ=0, num=0, avail=8, full=0, gate_open=0 at once, with no clock edge needed.
- Single entry: entry_req high for one cycle from IDLE with occ=0 -> entry_grant pulse with grant_slot=0, then gate_open high for exactly 4 cycles, then occ=8'h01, num=1, avail=7.
- Lowest-free fill: occ=8'b1011_0111, entry_req -> grant_slot=3, after which occ=8'hBF. Continue until full: full=1, avail=0, and a further entry_req gives no grant.
- Full with pending entry: occ=8'hFF, entry_req held, exit_valid with exit_slot=5 -> occ=8'hDF one cycle later, then grant with grant_slot=5 on the following cycle, then occ=8'hFF.
- Bad exit: exit_valid with exit_slot=2 while occ[2]=0 -> exit_err pulses for 1 cycle and occ is unchanged.
- Concurrent events: in the GRANT cycle for slot 1, also exit slot 4 -> both applied, occ goes from 8'h11 to 8'h03.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared definitions for the parking allocation slice.
//   - state_e     : allocation FSM states (IDLE, GRANT, OPEN)
//   - DEF_*       : default slot count and gate-open duration
//   - CNT_W       : width of the occupied/available counts
//   - popcount    : occupancy bit count, shared with the occupancy counter
package parking_pkg;

  localparam int DEF_NUM_SLOTS   = 8;
  localparam int DEF_GATE_CYCLES = 4;
  localparam int CNT_W           = 4;
  localparam int MAX_SLOTS       = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    OPEN  = 2'd2
  } state_e;

  // Counts set bits in a zero-extended occupancy vector; at most 15 slots, so
  // the result always fits CNT_W bits.
  function automatic logic [CNT_W-1:0] popcount(input logic [MAX_SLOTS-1:0] v);
    logic [CNT_W-1:0] c;
    c = {CNT_W{1'b0}};
    for (int i = 0; i < MAX_SLOTS; i++) begin
      c = c + {{(CNT_W-1){1'b0}}, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/parking_free_find.sv
// Lowest-index free slot priority encoder (purely combinational).
//   occ      : occupancy vector, bit i = slot i occupied
//   idx      : index of the lowest free slot (0 when none is free)
//   any_free : at least one slot is free
module parking_free_find
  import parking_pkg::*;
#(
  parameter int NUM_SLOTS = DEF_NUM_SLOTS,
  parameter int IDW       = $clog2(NUM_SLOTS)
) (
  input  logic [NUM_SLOTS-1:0] occ,
  output logic [IDW-1:0]       idx,
  output logic                 any_free
);

  // Scan from the top down so the last free slot seen is the lowest one.
  always_comb begin
    idx      = {IDW{1'b0}};
    any_free = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!occ[i]) begin
        idx      = IDW'(i);
        any_free = 1'b1;
      end else begin
        idx      = idx;
        any_free = any_free;
      end
    end
  end

endmodule

// File: rtl/parking_alloc.sv
// Parking entry allocator: grants the lowest free slot to a waiting car,
// holds the entry gate open for GATE_CYCLES cycles, and frees slots on exit.
//   clk, rst    : clock and asynchronous active-high reset
//   entry_req   : car waiting at entry (level, held until entry_grant)
//   exit_valid  : one-cycle pulse, car in exit_slot has left
//   exit_slot   : slot being vacated
//   entry_grant : one-cycle grant pulse, grant_slot valid with it
//   grant_slot  : allocated slot index, holds last value otherwise
//   gate_open   : entry barrier open
//   exit_err    : exit for a free or out-of-range slot
//   occ         : registered occupancy vector
//   num, avail  : occupied and free counts
//   full        : every slot occupied
module parking_alloc
  import parking_pkg::*;
#(
  parameter int NUM_SLOTS   = DEF_NUM_SLOTS,
  parameter int GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int IDW         = $clog2(NUM_SLOTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 entry_req,
  input  logic                 exit_valid,
  input  logic [IDW-1:0]       exit_slot,
  output logic                 entry_grant,
  output logic [IDW-1:0]       grant_slot,
  output logic                 gate_open,
  output logic                 exit_err,
  output logic [NUM_SLOTS-1:0] occ,
  output logic [CNT_W-1:0]     num,
  output logic [CNT_W-1:0]     avail,
  output logic                 full
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_GRANT = GRANT;
  localparam logic [1:0] S_OPEN  = OPEN;

  // The counter is loaded with GATE_CYCLES-1 and OPEN ends when it reads zero.
  localparam int             GCW       = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GCW-1:0] GATE_LOAD = GCW'(GATE_CYCLES - 1);

  logic [1:0]           state;
  logic [1:0]           state_nxt;
  logic [GCW-1:0]       gate_cnt;
  logic [IDW-1:0]       free_idx;
  logic                 any_free;
  logic                 take;
  logic                 exit_hit;
  logic [NUM_SLOTS-1:0] exit_mask;
  logic [NUM_SLOTS-1:0] set_mask;

  parking_free_find #(
    .NUM_SLOTS (NUM_SLOTS),
    .IDW       (IDW)
  ) u_free_find (
    .occ      (occ),
    .idx      (free_idx),
    .any_free (any_free)
  );

  // A request is only accepted from IDLE and only when a slot is free.
  assign take = (state == S_IDLE) && entry_req && any_free;

  // Exit clears only an occupied, in-range slot; out-of-range indices never
  // match any bit, so they fall through to exit_err.
  always_comb begin
    exit_mask = {NUM_SLOTS{1'b0}};
    set_mask  = {NUM_SLOTS{1'b0}};
    for (int i = 0; i < NUM_SLOTS; i++) begin
      exit_mask[i] = exit_valid && (exit_slot == IDW'(i)) && occ[i];
      set_mask[i]  = (state == S_GRANT) && (grant_slot == IDW'(i));
    end
    exit_hit = |exit_mask;
  end

  // Next-state logic of the allocation FSM.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (take) begin
          state_nxt = S_GRANT;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_GRANT: state_nxt = S_OPEN;
      S_OPEN: begin
        if (gate_cnt == {GCW{1'b0}}) begin
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_OPEN;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM state, gate counter and registered grant/gate/error outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      gate_cnt    <= {GCW{1'b0}};
      entry_grant <= 1'b0;
      grant_slot  <= {IDW{1'b0}};
      gate_open   <= 1'b0;
      exit_err    <= 1'b0;
    end else begin
      state       <= state_nxt;
      entry_grant <= (state_nxt == S_GRANT);
      gate_open   <= (state_nxt == S_OPEN);
      exit_err    <= exit_valid && !exit_hit;
      if (take) begin
        grant_slot <= free_idx;
      end else begin
        grant_slot <= grant_slot;
      end
      if (state == S_GRANT) begin
        gate_cnt <= GATE_LOAD;
      end else if ((state == S_OPEN) && (gate_cnt != {GCW{1'b0}})) begin
        gate_cnt <= gate_cnt - {{(GCW-1){1'b0}}, 1'b1};
      end else begin
        gate_cnt <= gate_cnt;
      end
    end
  end

  // Occupancy register: exit clear and grant set never hit the same bit,
  // because the granted slot was free when it was chosen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ <= {NUM_SLOTS{1'b0}};
    end else begin
      occ <= (occ & ~exit_mask) | set_mask;
    end
  end

  assign num   = popcount(MAX_SLOTS'(occ));
  assign avail = CNT_W'(NUM_SLOTS) - num;
  assign full  = &occ;

endmodule

// File: tb/tb_parking_alloc.sv
// Randomized self-checking bench for parking_alloc, compared every cycle
// against a cycle-timeline reference model of the allocation rules.
module tb_parking_alloc;

  localparam int NS = 8;
  localparam int GC = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       entry_req;
  logic       exit_valid;
  logic [2:0] exit_slot;
  logic       entry_grant;
  logic [2:0] grant_slot;
  logic       gate_open;
  logic       exit_err;
  logic [7:0] occ;
  logic [3:0] num;
  logic [3:0] avail;
  logic       full;

  int errors = 0;
  int checks = 0;

  // Reference model: parked cars, pending grant, remaining gate cycles.
  bit [7:0] m_occ;
  bit       m_grant;
  int       m_slot;
  int       m_gate;
  bit       m_err;

  parking_alloc #(.NUM_SLOTS(NS), .GATE_CYCLES(GC)) dut (
    .clk         (clk),
    .rst         (rst),
    .entry_req   (entry_req),
    .exit_valid  (exit_valid),
    .exit_slot   (exit_slot),
    .entry_grant (entry_grant),
    .grant_slot  (grant_slot),
    .gate_open   (gate_open),
    .exit_err    (exit_err),
    .occ         (occ),
    .num         (num),
    .avail       (avail),
    .full        (full)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int lowest_free(input bit [7:0] o);
    for (int i = 0; i < NS; i++) begin
      if (!o[i]) return i;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_occ   = 8'h00;
    m_grant = 1'b0;
    m_slot  = 0;
    m_gate  = 0;
    m_err   = 1'b0;
  endtask

  // Applies one clock edge to the model using pre-edge values.
  task automatic model_edge(input bit req, input bit ev, input int es);
    bit [7:0] o;
    o = m_occ;
    m_err = ev && !(es < NS && o[es]);
    if (ev && es < NS && o[es]) m_occ[es] = 1'b0;
    if (m_grant) begin
      m_occ[m_slot] = 1'b1;
      m_grant = 1'b0;
      m_gate  = GC;
    end else if (m_gate > 0) begin
      m_gate--;
    end else if (req && o != 8'hFF) begin
      m_grant = 1'b1;
      m_slot  = lowest_free(o);
    end
  endtask

  task automatic compare_all();
    int n;
    n = $countones(m_occ);
    check_eq("entry_grant", int'(entry_grant), int'(m_grant));
    check_eq("grant_slot",  int'(grant_slot),  m_slot);
    check_eq("gate_open",   int'(gate_open),   int'(m_gate > 0));
    check_eq("exit_err",    int'(exit_err),    int'(m_err));
    check_eq("occ",         int'(occ),         int'(m_occ));
    check_eq("num",         int'(num),         n);
    check_eq("avail",       int'(avail),       NS - n);
    check_eq("full",        int'(full),        int'(m_occ == 8'hFF));
  endtask

  // Checks the current cycle, drives new inputs, then advances one edge.
  task automatic step(input bit req, input bit ev, input int es);
    @(negedge clk);
    compare_all();
    entry_req  = req;
    exit_valid = ev;
    exit_slot  = 3'(es);
    @(posedge clk);
    model_edge(req, ev, es);
  endtask

  initial begin
    rst        = 1'b1;
    entry_req  = 1'b0;
    exit_valid = 1'b0;
    exit_slot  = 3'd0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    compare_all();
    rst = 1'b0;

    // Random traffic: busy exits first, then sparse exits so the lot fills.
    for (int c = 0; c < 1500; c++) begin
      int exit_pct;
      exit_pct = (c < 750) ? 30 : 8;
      step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < exit_pct,
           int'($urandom_range(0, NS - 1)));
    end

    // Drain, then fill from empty with a continuously held request.
    for (int s = 0; s < NS; s++) step(1'b0, 1'b1, s);
    for (int c = 0; c < 70; c++) step(1'b1, 1'b0, 0);

    // Full lot with request pending: exit slot 5, expect it to be re-granted.
    step(1'b1, 1'b1, 5);
    for (int c = 0; c < 3; c++) step(1'b1, 1'b0, 0);

    // Wait (bounded) until the gate is open, then reset asynchronously.
    for (int k = 0; k < 20 && m_gate == 0; k++) step(1'b0, 1'b0, 0);
    #1;
    check_eq("gate_before_rst", int'(gate_open), 1);
    #1;
    rst        = 1'b1;
    entry_req  = 1'b0;
    exit_valid = 1'b0;
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    rst = 1'b0;

    for (int c = 0; c < 300; c++) begin
      step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 20,
           int'($urandom_range(0, NS - 1)));
    end
    @(negedge clk);
    compare_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
